// File: rtl/pipe_chain_pkg.sv
// Shared pipeline constants: default chain geometry and the occupancy-counter width,
// used by both the stage datapath and the chain controller.
package pipe_chain_pkg;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_DEPTH       = 4;
   localparam int DEF_HOLD_STAGE  = 2;
   localparam int DEF_FLUSH_DEPTH = 2;

   // Enough bits to represent 0..depth valid stages.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One pipeline slot: a valid bit plus payload register with load / unload / kill controls.
// Kill has priority, then load (covers load-while-emptying), then unload leaves a bubble.
module pipe_chain_stage
   import pipe_chain_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             unload,
   input  logic             kill,
   input  logic [WIDTH-1:0] din,
   output logic             valid,
   output logic             valid_nxt,
   output logic [WIDTH-1:0] data
);

   always_comb begin
      valid_nxt = valid;
      if (kill) begin
         valid_nxt = 1'b0;
      end else if (load) begin
         valid_nxt = 1'b1;
      end else if (unload) begin
         valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         valid <= valid_nxt;
         if (load && !kill) begin
            data <= din;
         end
      end
   end

endmodule

// File: rtl/pipe_chain.sv
// Elastic in-order register chain with bubble collapse, a load-use style hold that
// injects a bubble at HOLD_STAGE, and a front-end flush of stages 0..FLUSH_DEPTH-1.
module pipe_chain
   import pipe_chain_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int HOLD_STAGE  = DEF_HOLD_STAGE,
   parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   input  logic                          hold,
   input  logic                          flush,
   output logic [cnt_width(DEPTH)-1:0]   count
);

   localparam int CW = cnt_width(DEPTH);

   logic [DEPTH-1:0]            v;
   logic [DEPTH-1:0]            v_nxt;
   logic [DEPTH-1:0]            move;
   logic [DEPTH-1:0]            load;
   logic [DEPTH-1:0][WIDTH-1:0] data;
   logic [DEPTH-1:0][WIDTH-1:0] din;
   logic                        accept;

   function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] bits);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n = n + CW'(bits[i]);
      end
      return n;
   endfunction

   // Advance chain, resolved from the output backwards: a stage may move when the
   // stage ahead is empty or is itself moving this cycle.
   always_comb begin
      logic free;
      move = '0;
      free = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         move[i] = v[i] & free;
         if (hold && (i < HOLD_STAGE)) begin
            move[i] = 1'b0;
         end
         if (flush && (i == FLUSH_DEPTH - 1)) begin
            move[i] = 1'b0;
         end
         free = !v[i] | move[i];
      end
   end

   assign in_ready = (!v[0] | move[0]) & !hold & !flush & reset;
   assign accept   = in_valid & in_ready;

   assign load = {move[DEPTH-2:0], accept};
   assign din  = {data[DEPTH-2:0], in_data};

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      pipe_chain_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .load      (load[g]),
         .unload    (move[g]),
         .kill      (flush && (g < FLUSH_DEPTH)),
         .din       (din[g]),
         .valid     (v[g]),
         .valid_nxt (v_nxt[g]),
         .data      (data[g])
      );
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = v[DEPTH-1] ? data[DEPTH-1] : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else begin
         count <= popcount(v_nxt);
      end
   end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed scenarios plus randomized traffic for pipe_chain, checked every cycle against
// a slot-occupancy model where an item advances whenever any downstream slot is open.
module tb_pipe_chain;

   localparam int D  = 4;
   localparam int HS = 2;
   localparam int FD = 2;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        hold;
   logic        flush;
   logic [2:0]  count;

   pipe_chain #(
      .WIDTH       (32),
      .DEPTH       (D),
      .HOLD_STAGE  (HS),
      .FLUSH_DEPTH (FD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .hold      (hold),
      .flush     (flush),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model state: occupancy and payload per slot, index D-1 is the output slot
   bit          mv  [D];
   logic [31:0] md  [D];
   bit          adv [D];
   bit          e_ir;

   logic        obs_ov, obs_ir;
   logic [31:0] obs_od;
   int          obs_cnt;
   logic [31:0] outs[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int occupancy();
      int n = 0;
      for (int i = 0; i < D; i++) n += int'(mv[i]);
      return n;
   endfunction

   function automatic bit gap_after(input int i);
      for (int j = i + 1; j < D; j++) if (!mv[j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_comb(input bit ordy, input bit h, input bit f, input bit rst);
      bit pop;
      pop = mv[D-1] && ordy;
      for (int i = 0; i < D; i++) begin
         adv[i] = mv[i] && (pop || gap_after(i));
         if (h && i < HS) adv[i] = 1'b0;
      end
      if (f) adv[FD-1] = 1'b0;
      e_ir = rst && !h && !f && (!mv[0] || adv[0]);
   endtask

   task automatic model_update(input bit acc, input logic [31:0] ind, input bit f, input bit rst);
      bit          nv [D];
      logic [31:0] nd [D];
      for (int i = 0; i < D; i++) begin
         nv[i] = mv[i] && !adv[i];
         nd[i] = md[i];
      end
      for (int i = 1; i < D; i++) begin
         if (adv[i-1]) begin
            nv[i] = 1'b1;
            nd[i] = md[i-1];
         end
      end
      if (acc) begin
         nv[0] = 1'b1;
         nd[0] = ind;
      end
      if (f) for (int i = 0; i < FD; i++) nv[i] = 1'b0;
      if (!rst) for (int i = 0; i < D; i++) begin
         nv[i] = 1'b0;
         nd[i] = '0;
      end
      for (int i = 0; i < D; i++) begin
         mv[i] = nv[i];
         md[i] = nd[i];
      end
   endtask

   // Drive one cycle (entered just after a rising edge), check at the falling edge.
   task automatic cycle(input bit iv, input logic [31:0] id, input bit ordy,
                        input bit h, input bit f, input bit rst);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      hold      = h;
      flush     = f;
      reset     = rst;
      model_comb(ordy, h, f, rst);
      @(negedge clk);
      obs_ov  = out_valid;
      obs_od  = out_data;
      obs_ir  = in_ready;
      obs_cnt = int'(count);
      chk("out_valid", 32'(out_valid), 32'(mv[D-1]));
      chk("out_data", out_data, mv[D-1] ? md[D-1] : 32'h0);
      chk("in_ready", 32'(in_ready), 32'(e_ir));
      chk("count", 32'(count), 32'(occupancy()));
      if (out_valid && ordy && rst && !(f && FD == D)) outs.push_back(out_data);
      @(posedge clk);
      model_update(iv && e_ir, id, f, rst);
      #1;
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, ordy, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic chk_outs(input string tag, input logic [31:0] exp[$]);
      chk({tag, "_len"}, 32'(outs.size()), 32'(exp.size()));
      for (int k = 0; k < exp.size() && k < outs.size(); k++) chk(tag, outs[k], exp[k]);
   endtask

   initial begin
      int idx;
      int peak;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      hold = 1'b0; flush = 1'b0; reset = 1'b0;
      for (int i = 0; i < D; i++) begin
         mv[i] = 1'b0;
         md[i] = '0;
      end
      @(posedge clk);
      #1;

      // reset state
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_in_ready", 32'(obs_ir), 32'h0);
      chk("rst_count", 32'(obs_cnt), 32'h0);

      // back-to-back stream, latency DEPTH
      outs.delete();
      peak = 0;
      for (int k = 0; k < 8; k++) begin
         cycle(k < 3, 32'h11 * (k + 1), 1'b1, 1'b0, 1'b0, 1'b1);
         if (k == 4) chk("stream_first", obs_od, 32'h11);
         if (k == 5) chk("stream_second", obs_od, 32'h22);
         if (k == 6) chk("stream_third", obs_od, 32'h33);
         if (obs_cnt > peak) peak = obs_cnt;
      end
      chk("stream_peak", 32'(peak), 32'd3);

      // backpressure and same-cycle refill
      outs.delete();
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, 32'h11 * (idx + 1), 1'b0, 1'b0, 1'b0, 1'b1);
         if (e_ir) idx++;
      end
      chk("bp_accepted", 32'(idx), 32'd4);
      chk("bp_ready_low", 32'(obs_ir), 32'h0);
      chk("bp_count_full", 32'(obs_cnt), 32'd4);
      cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("bp_pop_data", obs_od, 32'h11);
      chk("bp_refill_ready", 32'(obs_ir), 32'h1);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("bp_count_kept", 32'(obs_cnt), 32'd4);
      idle(8, 1'b1);
      chk_outs("bp_order", '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55});

      // bubble collapse under a stalled output
      outs.delete();
      cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);
      cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(5, 1'b0);
      chk("collapse_count", 32'(obs_cnt), 32'd2);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("collapse_head", obs_od, 32'hA);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("collapse_no_gap_valid", 32'(obs_ov), 32'h1);
      chk("collapse_no_gap_data", obs_od, 32'hB);
      idle(2, 1'b1);

      // hold: front frozen, bubble injected at HOLD_STAGE
      outs.delete();
      for (int k = 0; k < 4; k++) cycle(1'b1, 32'h21 + k, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("hold_count0", 32'(obs_cnt), 32'd4);
      chk("hold_ready0", 32'(obs_ir), 32'h0);
      cycle(1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("hold_count1", 32'(obs_cnt), 32'd3);
      chk("hold_ready1", 32'(obs_ir), 32'h0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("hold_count2", 32'(obs_cnt), 32'd2);
      idle(6, 1'b1);
      chk_outs("hold_order", '{32'h21, 32'h22, 32'h23, 32'h24});

      // flush kills stages 0..FD-1
      outs.delete();
      for (int k = 0; k < 4; k++) cycle(1'b1, 32'h1 + k, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("flush_count_before", 32'(obs_cnt), 32'd4);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("flush_count_after", 32'(obs_cnt), 32'd2);
      idle(6, 1'b1);
      chk_outs("flush_survivors", '{32'h1, 32'h2});

      // mid-stream reset, then immediate acceptance
      outs.delete();
      for (int k = 0; k < 3; k++) cycle(1'b1, 32'h61 + k, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_ready", 32'(obs_ir), 32'h0);
      cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("rst_mid_valid", 32'(obs_ov), 32'h0);
      chk("rst_mid_count", 32'(obs_cnt), 32'h0);
      chk("rst_mid_data", obs_od, 32'h0);
      chk("rst_first_accept", 32'(obs_ir), 32'h1);
      for (int k = 1; k <= 4; k++) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
         if (k == 4) begin
            chk("rst_latency_valid", 32'(obs_ov), 32'h1);
            chk("rst_latency_data", obs_od, 32'h55);
         end
      end
      idle(2, 1'b1);
      chk_outs("rst_no_partial", '{32'h55});

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
               $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 49) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
